// File: rtl/hex_scan_display_if.sv
// Host-to-display bundle for hex_scan_display: shadow-capture inputs from the
// game/score logic and the multiplexed segment/digit pins toward the board.
interface hex_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic                      lzb;
    logic [NUM_DIGITS-1:0]     blink;
    logic [6:0]                seg_out;
    logic                      dp_out;
    logic [NUM_DIGITS-1:0]     dig_sel;

    modport master (
        output load, value, dp, digit_en, lzb, blink,
        input  seg_out, dp_out, dig_sel
    );

    modport slave (
        input  load, value, dp, digit_en, lzb, blink,
        output seg_out, dp_out, dig_sel
    );
endinterface

// File: rtl/hex_scan_display.sv
// Multiplexed hex display driver: scans NUM_DIGITS shadowed nibbles onto one segment bus.
// Define SEG_BLINK_EN to enable per-digit blinking (phase toggles every 64 scan frames).
module hex_scan_display #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    hex_scan_display_if.slave bus
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_DARK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic          DP_DARK  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_NONE = DIG_ACTIVE_LOW ? '1 : '0;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    logic [4*NUM_DIGITS-1:0] sh_value;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic                    sh_lzb;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          frame_wrap;

    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  blink_off;
    logic                  lit;
    logic [NUM_DIGITS-1:0] onehot;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [NUM_DIGITS-1:0] dig_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_value <= '0;
            sh_dp    <= '0;
            sh_en    <= '0;
            sh_lzb   <= 1'b0;
        end else if (bus.load) begin
            sh_value <= bus.value;
            sh_dp    <= bus.dp;
            sh_en    <= bus.digit_en;
            sh_lzb   <= bus.lzb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
        end
    end

    // Every digit owns a slot whether lit or not, so brightness is independent of content.
    always_comb begin
        cnt_nxt    = cnt + 1'b1;
        idx_nxt    = idx;
        frame_wrap = 1'b0;
        if (cnt == CNT_MAX) begin
            cnt_nxt = '0;
            if (idx == IDX_MAX) begin
                idx_nxt    = '0;
                frame_wrap = 1'b1;
            end else begin
                idx_nxt = idx + 1'b1;
            end
        end
    end

`ifdef SEG_BLINK_EN
    logic [5:0] frame_cnt;
    logic       blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (frame_cnt == 6'd63)
                blink_phase <= ~blink_phase;
        end
    end

    assign blink_off = blink_phase & bus.blink[idx];
`else
    logic unused_frame_wrap;
    assign unused_frame_wrap = frame_wrap;
    assign blink_off = 1'b0;
`endif

    // upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            nib[i] = sh_value[4*i +: 4];
        upper_zero[NUM_DIGITS-1] = (nib[NUM_DIGITS-1] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            upper_zero[i] = upper_zero[i+1] && (nib[i] == 4'h0);
    end

    always_comb begin
        lit = (int'(cnt) >= GUARD_CYCLES)
              && sh_en[idx]
              && !(sh_lzb && (idx != '0) && upper_zero[idx])
              && !blink_off;
        onehot  = NUM_DIGITS'(1) << idx;
        seg_nxt = SEG_DARK;
        dp_nxt  = DP_DARK;
        dig_nxt = DIG_NONE;
        if (lit) begin
            seg_nxt = SEG_ACTIVE_LOW ? ~glyph(nib[idx]) : glyph(nib[idx]);
            dp_nxt  = sh_dp[idx] ^ SEG_ACTIVE_LOW;
            dig_nxt = DIG_ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.seg_out <= SEG_DARK;
            bus.dp_out  <= DP_DARK;
            bus.dig_sel <= DIG_NONE;
        end else begin
            bus.seg_out <= seg_nxt;
            bus.dp_out  <= dp_nxt;
            bus.dig_sel <= dig_nxt;
        end
    end

endmodule
